// File: rtl/cpc_rom_loader.sv
// ROM download loader: maps hps_io index-0 bytes onto SDRAM pages/banks and
// drains them through a small FIFO into the SDRAM boot write port, one per ce_ref.
//
// state   | meaning
// S_IDLE  | no boot write presented; boot_wr low
// S_WRITE | boot_a/bank/dout hold a write the SDRAM samples at the next ce_ref
module cpc_rom_loader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ce_ref,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_dout,
    output logic        o_ioctl_wait,
    output logic        o_boot_wr,
    output logic [22:0] o_boot_a,
    output logic [1:0]  o_boot_bank,
    output logic [7:0]  o_boot_dout,
    output logic        o_active,
    output logic        o_done,
    output logic [15:0] o_skipped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] WAIT_CNT = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [32:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;

    logic        r_wait;
    logic [22:0] r_boot_a;
    logic [1:0]  r_boot_bank;
    logic [7:0]  r_boot_dout;
    logic        r_active;
    logic        r_done;
    logic        r_dl_d;
    logic [15:0] r_skipped;

    logic        w_dl0;
    logic        w_accept;
    logic [10:0] w_slot;
    logic        w_in_range;
    logic [8:0]  w_page;
    logic [32:0] w_entry;
    logic [32:0] w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_skip;
    logic        w_clear;

    assign w_dl0      = i_ioctl_download & (i_ioctl_index == 8'd0);
    assign w_accept   = w_dl0 & i_ioctl_wr;
    assign w_slot     = i_ioctl_addr[24:14];
    assign w_in_range = (w_slot[10:3] == 8'd0);
    assign w_skip     = w_accept & ~w_in_range;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == FULL_CNT);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // a full FIFO can still take a byte in the same cycle it pops one
    assign w_push  = w_accept & w_in_range & (~w_full | w_pop);

    always_comb begin
        w_page = 9'h000;
        case (w_slot[1:0])
            2'd0:    w_page = 9'h000;
            2'd1:    w_page = 9'h100;
            2'd2:    w_page = 9'h107;
            default: w_page = 9'h1ff;
        endcase
    end

    assign w_entry = {1'b0, w_slot[2], w_page, i_ioctl_addr[13:0], i_ioctl_dout};

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ce_ref && !w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_ce_ref) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    assign w_clear = ~i_ioctl_download & w_empty & (r_state == S_IDLE);

    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wait      <= 1'b0;
            r_boot_a    <= '0;
            r_boot_bank <= '0;
            r_boot_dout <= '0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_dl_d      <= 1'b0;
            r_skipped   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr                               <= r_rd_ptr + PTR_ONE;
                {r_boot_bank, r_boot_a, r_boot_dout}   <= w_head;
            end
            r_wait <= (w_count >= WAIT_CNT);
            if (w_skip && (r_skipped != 16'hFFFF)) begin
                r_skipped <= r_skipped + 16'd1;
            end
            r_dl_d <= w_dl0;
            r_done <= r_active & w_clear;
            if (w_dl0 && !r_dl_d) begin
                r_active <= 1'b1;
            end else if (w_clear) begin
                r_active <= 1'b0;
            end
        end
    end

    // hps_io must have honoured ioctl_wait; a byte arriving into a full FIFO is lost
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset) begin
            assert (!(w_accept && w_in_range && w_full && !w_pop));
        end
    end

    assign o_ioctl_wait = r_wait;
    assign o_boot_wr    = (r_state == S_WRITE);
    assign o_boot_a     = r_boot_a;
    assign o_boot_bank  = r_boot_bank;
    assign o_boot_dout  = r_boot_dout;
    assign o_active     = r_active;
    assign o_done       = r_done;
    assign o_skipped    = r_skipped;

endmodule

// File: doc/cpc_rom_loader.md
# cpc_rom_loader

Moves the HPS ROM download stream (ioctl, index 0) into the SDRAM boot write port in the `clk_sys` domain. It maps the 16 KB ROM slots of the download image onto fixed SDRAM pages and banks, and buffers bytes in a small FIFO. Writes are paced by the SDRAM `ce_ref` slot, and `ioctl_wait` throttles hps_io when the FIFO is nearly full. It sits between hps_io and the sdram controller's boot path, and its `active` output holds the CPU in reset while a load is in progress.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce_ref` in 1: SDRAM slot strobe; at most one boot write per `ce_ref` period (16 clocks in system).
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download type; only 0 is handled.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_addr` in 25: byte offset in the image.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: registered stall request to hps_io.
- `boot_wr` out 1: SDRAM write request.
- `boot_a` out 23: SDRAM byte address.
- `boot_bank` out 2: SDRAM bank.
- `boot_dout` out 8: write data.
- `active` out 1: ROM load in progress; ORed into the system reset.
- `done` out 1: one-cycle pulse when a load completes.
- `skipped` out 16: count of bytes dropped as out of range; saturating.

## Operation
- Accept condition: `ioctl_download & ioctl_index==0 & ioctl_wr`.
- Slot `s = ioctl_addr[24:14]`.
- Page mapping for `boot_a[22:14]`:
  - s=0 or 4 → 9'h000
  - s=1 or 5 → 9'h100
  - s=2 or 6 → 9'h107
  - s=3 or 7 → 9'h1ff (MF2)
- `boot_a[13:0] = ioctl_addr[13:0]`.
- Bank: 0 for s=0..3, 1 for s=4..7. `boot_bank[1]` is always 0.
- s ≥ 8: the byte is not pushed and `skipped` increments, holding at 16'hFFFF.
- FIFO entry is {bank, addr, data} (33 bits significant). Push and pop in the same cycle leaves the count unchanged.
- `ioctl_wait` is registered: it is 1 in the cycle after the count reaches ≥ FIFO_DEPTH−1, and 0 in the cycle after the count drops below FIFO_DEPTH−1.
  - The one spare slot absorbs the single byte hps_io may issue while `ioctl_wait` is still propagating.
  - A push into a full FIFO is a design error; the bench flags it and RTL asserts on it in simulation.
- Drain FSM:
  - IDLE: `boot_wr`=0. On `ce_ref` with the FIFO not empty: pop the head into `boot_a`/`boot_bank`/`boot_dout`, set `boot_wr`=1, go to WRITE.
  - WRITE: on `ce_ref` with the FIFO not empty: pop the next entry and stay in WRITE (back-to-back). On `ce_ref` with the FIFO empty: `boot_wr`=0, go to IDLE.
- `active`:
  - Set on the rising edge of `ioctl_download & ioctl_index==0`.
  - Cleared when the download is low, the FIFO is empty and the FSM is in IDLE.
  - `done` pulses in the cycle `active` falls.
- Downloads with a non-zero index are ignored entirely: no push, no `active`, no change to `skipped`.

## Timing
- Reset values: `ioctl_wait`=0, `boot_wr`=0, `boot_a`=0, `boot_bank`=0, `boot_dout`=0, `active`=0, `done`=0, `skipped`=0, FIFO empty, FSM in IDLE.
- Reset mid-load flushes the FIFO, aborts any write (`boot_wr`=0 the next cycle) and clears `skipped`.
- Push latency: a byte strobed at edge T is in the FIFO at T+1. Its `boot_wr` rises at the first `ce_ref` edge after T+1.
- `boot_*` outputs change only on `clk_sys` edges where `ce_ref`=1, and stay stable for the full `ce_ref` period. The SDRAM samples them at the next `ce_ref`.
- Sustained throughput is one byte per `ce_ref` period. `ioctl_wait` is asserted whenever input outruns it.
- If `ioctl_download` falls while the FIFO is non-empty, the drain continues. `active` stays high until the last write period ends.

## Test plan
- Single byte at addr 0x00005, data 0xA5, `ce_ref` every 16 clocks → one `boot_wr` period with `boot_a`=0x000005, bank 0, data 0xA5. `active` falls and `done` pulses after that period.
- Byte at addr 0x08010 (s=2), then 0x1C003 (s=7) → `boot_a`=0x41C010 bank 0, then 0x7FC003 bank 1.
- Burst of 8 bytes, one per clock, FIFO_DEPTH=4 → `ioctl_wait` is 1 in the cycle after the count reaches 3. No overflow occurs, and all 8 bytes are written in order on consecutive `ce_ref` periods with `boot_wr` held high throughout.
- Bytes at addr 0x20000 and 0x20001 (s=8) → no `boot_wr`, `skipped`=2, `active` falls with the download.
- Download with `ioctl_index`=1 → no writes, `active` stays 0.
- `reset` asserted with 3 entries queued and `boot_wr`=1 → next cycle `boot_wr`=0, FIFO empty, `ioctl_wait`=0, `active`=0, no `done` pulse.
